// File: rtl/write_to_read_sync_level.sv
// Read-domain receiver for the async FIFO write pointer: N-flop Gray synchroniser,
// Gray-to-binary conversion, fill level / empty flags and sticky pointer-integrity checks.
module write_to_read_sync_level #(
    parameter int unsigned addr_size          = 3,
    parameter int unsigned sync_stages        = 2,
    parameter int unsigned almost_empty_level = 1
) (
    input  logic                 read_clock_i,
    input  logic                 read_reset_n_i,
    input  logic [addr_size:0]   write_pointer_gray_i,
    input  logic [addr_size:0]   read_pointer_bin_i,
    input  logic                 error_clear_i,
    output logic [addr_size:0]   write_to_read_pointer_o,
    output logic [addr_size:0]   write_to_read_pointer_bin_o,
    output logic [addr_size:0]   fill_level_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 pointer_valid_o,
    output logic                 gray_error_o,
    output logic                 level_error_o
);

    localparam int unsigned pw = addr_size + 1;
    localparam logic [pw-1:0] depth_value = {1'b1, {addr_size{1'b0}}};
    localparam logic [pw-1:0] almost_empty_value = pw'(almost_empty_level);
    localparam logic [2:0] count_max = 3'(sync_stages + 1);
    localparam logic [2:0] count_warm = 3'(sync_stages);

    if (sync_stages < 2 || sync_stages > 4) begin : gen_bad_stages
        $error("sync_stages must be in 2..4");
    end

    logic [pw-1:0] sync_q [sync_stages];
    logic [pw-1:0] prev_q;
    logic [pw-1:0] bin_q;
    logic [pw-1:0] fill_q;
    logic          empty_q;
    logic          almost_empty_q;
    logic [2:0]    count_q;
    logic          gray_error_q;
    logic          level_error_q;

    logic [pw-1:0] stage_last;
    logic [pw-1:0] write_bin;
    logic [pw-1:0] fill_next;
    logic          valid;
    logic          warm_done;
    logic          gray_bad;
    logic          level_bad;
    logic          gray_error_d;
    logic          level_error_d;

    assign stage_last = sync_q[sync_stages-1];
    assign valid      = (count_q == count_max);
    // Flags computed on the edge that makes the counter valid already see real chain data.
    assign warm_done  = (count_q >= count_warm);

    always_comb begin
        write_bin = '0;
        write_bin[pw-1] = stage_last[pw-1];
        for (int i = int'(pw) - 2; i >= 0; i--) begin
            write_bin[i] = write_bin[i+1] ^ stage_last[i];
        end
        fill_next = write_bin - read_pointer_bin_i;
        gray_bad  = ($countones(prev_q ^ stage_last) > 1);
        level_bad = (fill_next > depth_value);
        // A new error on the same edge as a clear keeps the flag set.
        if (valid && gray_bad) begin
            gray_error_d = 1'b1;
        end else if (error_clear_i) begin
            gray_error_d = 1'b0;
        end else begin
            gray_error_d = gray_error_q;
        end
        if (valid && level_bad) begin
            level_error_d = 1'b1;
        end else if (error_clear_i) begin
            level_error_d = 1'b0;
        end else begin
            level_error_d = level_error_q;
        end
    end

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            for (int k = 0; k < int'(sync_stages); k++) begin
                sync_q[k] <= '0;
            end
            prev_q         <= '0;
            bin_q          <= '0;
            fill_q         <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            count_q        <= '0;
            gray_error_q   <= 1'b0;
            level_error_q  <= 1'b0;
        end else begin
            sync_q[0] <= write_pointer_gray_i;
            for (int k = 1; k < int'(sync_stages); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q         <= stage_last;
            bin_q          <= write_bin;
            fill_q         <= fill_next;
            empty_q        <= !warm_done || (fill_next == '0);
            almost_empty_q <= !warm_done || (fill_next <= almost_empty_value);
            if (count_q != count_max) begin
                count_q <= count_q + 3'd1;
            end
            gray_error_q  <= gray_error_d;
            level_error_q <= level_error_d;
        end
    end

    assign write_to_read_pointer_o     = stage_last;
    assign write_to_read_pointer_bin_o = bin_q;
    assign fill_level_o                = fill_q;
    assign empty_o                     = empty_q;
    assign almost_empty_o              = almost_empty_q;
    assign pointer_valid_o             = valid;
    assign gray_error_o                = gray_error_q;
    assign level_error_o               = level_error_q;

endmodule

// File: tb/tb_write_to_read_sync_level.sv
// Randomised bench for write_to_read_sync_level: two instances (2 and 4 stages) share the
// inputs and are compared each cycle against an input-history reference model.
module tb_write_to_read_sync_level;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] wg = '0;
    logic [3:0] rp = '0;
    logic       clr = 1'b0;

    logic [1:0][3:0] ptr_s, bin_s, fill_s;
    logic [1:0]      empty_s, ae_s, valid_s, gerr_s, lerr_s;

    write_to_read_sync_level #(.addr_size(3), .sync_stages(2), .almost_empty_level(1)) dut2 (
        .read_clock_i               (clk),
        .read_reset_n_i             (rst_n),
        .write_pointer_gray_i       (wg),
        .read_pointer_bin_i         (rp),
        .error_clear_i              (clr),
        .write_to_read_pointer_o    (ptr_s[0]),
        .write_to_read_pointer_bin_o(bin_s[0]),
        .fill_level_o               (fill_s[0]),
        .empty_o                    (empty_s[0]),
        .almost_empty_o             (ae_s[0]),
        .pointer_valid_o            (valid_s[0]),
        .gray_error_o               (gerr_s[0]),
        .level_error_o              (lerr_s[0])
    );

    write_to_read_sync_level #(.addr_size(3), .sync_stages(4), .almost_empty_level(1)) dut4 (
        .read_clock_i               (clk),
        .read_reset_n_i             (rst_n),
        .write_pointer_gray_i       (wg),
        .read_pointer_bin_i         (rp),
        .error_clear_i              (clr),
        .write_to_read_pointer_o    (ptr_s[1]),
        .write_to_read_pointer_bin_o(bin_s[1]),
        .fill_level_o               (fill_s[1]),
        .empty_o                    (empty_s[1]),
        .almost_empty_o             (ae_s[1]),
        .pointer_valid_o            (valid_s[1]),
        .gray_error_o               (gerr_s[1]),
        .level_error_o              (lerr_s[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // History of sampled inputs, indexed by global edge number; r marks the last reset release.
    logic [3:0] in_h [0:4095];
    logic [3:0] rp_h [0:4095];
    logic       clr_h [0:4095];
    int         g = 0;
    int         r = 0;
    logic       gerr_m [2];
    logic       lerr_m [2];
    int         stages [2] = '{2, 4};

    function automatic logic [3:0] in_at(input int k);
        return (k >= 1) ? in_h[r+k] : 4'd0;
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] x);
        return x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3);
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic model_and_check(input int i);
        int         s;
        int         n;
        logic [3:0] src;
        logic [3:0] bin;
        logic [3:0] fill;
        logic       gset;
        logic       lset;
        s = stages[i];
        n = g - r;
        src = in_at(n - s);
        bin = g2b(src);
        fill = bin - rp_h[g];
        gset = 1'b0;
        lset = 1'b0;
        if (n - 1 >= s + 1) begin
            gset = ($countones(in_at(n - s - 1) ^ src) > 1);
            lset = (fill > 4'd8);
        end
        gerr_m[i] = gset ? 1'b1 : (clr_h[g] ? 1'b0 : gerr_m[i]);
        lerr_m[i] = lset ? 1'b1 : (clr_h[g] ? 1'b0 : lerr_m[i]);
        check_eq($sformatf("s%0d e%0d gray", s, n), ptr_s[i], in_at(n - s + 1));
        check_eq($sformatf("s%0d e%0d bin", s, n), bin_s[i], bin);
        check_eq($sformatf("s%0d e%0d fill", s, n), fill_s[i], fill);
        check_eq($sformatf("s%0d e%0d empty", s, n), empty_s[i], (n <= s) || (fill == 0));
        check_eq($sformatf("s%0d e%0d almost_empty", s, n), ae_s[i], (n <= s) || (fill <= 1));
        check_eq($sformatf("s%0d e%0d valid", s, n), valid_s[i], n >= s + 1);
        check_eq($sformatf("s%0d e%0d gray_error", s, n), gerr_s[i], gerr_m[i]);
        check_eq($sformatf("s%0d e%0d level_error", s, n), lerr_s[i], lerr_m[i]);
    endtask

    // Called at a negedge; applies inputs for the next edge, then checks at the following negedge.
    task automatic step(input logic [3:0] wgray, input logic [3:0] rptr, input logic c);
        wg = wgray;
        rp = rptr;
        clr = c;
        @(posedge clk);
        g++;
        in_h[g] = wgray;
        rp_h[g] = rptr;
        clr_h[g] = c;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_and_check(i);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst s%0d gray", stages[i]), ptr_s[i], 4'd0);
            check_eq($sformatf("rst s%0d bin", stages[i]), bin_s[i], 4'd0);
            check_eq($sformatf("rst s%0d fill", stages[i]), fill_s[i], 4'd0);
            check_eq($sformatf("rst s%0d empty", stages[i]), empty_s[i], 1'b1);
            check_eq($sformatf("rst s%0d almost_empty", stages[i]), ae_s[i], 1'b1);
            check_eq($sformatf("rst s%0d valid", stages[i]), valid_s[i], 1'b0);
            check_eq($sformatf("rst s%0d gray_error", stages[i]), gerr_s[i], 1'b0);
            check_eq($sformatf("rst s%0d level_error", stages[i]), lerr_s[i], 1'b0);
            gerr_m[i] = 1'b0;
            lerr_m[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = g;
    endtask

    initial begin
        logic [3:0] wb;
        logic [3:0] bad;
        int         roll;
        @(negedge clk);
        do_reset();

        // Idle warm-up, then a few single-step increments.
        repeat (5) step(4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 3; k++) step(b2g(4'(k)), 4'd0, 1'b0);
        repeat (6) step(b2g(4'd3), 4'd0, 1'b0);

        // Walk to 15 with fill 3, then wrap to 0 with the read pointer at 12.
        for (int k = 4; k <= 15; k++) step(b2g(4'(k)), 4'(k - 3), 1'b0);
        repeat (7) step(4'd0, 4'd12, 1'b0);

        // Illegal jump, clear, then a clear coinciding with a second detection on the 2-stage part.
        repeat (7) step(4'b0011, 4'd0, 1'b0);
        step(4'b0011, 4'd0, 1'b1);
        repeat (6) step(4'b0011, 4'd0, 1'b0);
        bad = 4'b0101;
        step(bad, 4'd0, 1'b0);
        step(bad, 4'd0, 1'b0);
        step(bad, 4'd0, 1'b1);
        check_eq("s2 gray_error held over clear", gerr_s[0], 1'b1);
        repeat (5) step(bad, 4'd0, 1'b0);

        // Over-range fill.
        repeat (8) step(b2g(4'd12), 4'd2, 1'b0);
        check_eq("s2 fill 10", fill_s[0], 4'd10);
        check_eq("s2 level_error", lerr_s[0], 1'b1);
        check_eq("s4 fill 10", fill_s[1], 4'd10);
        check_eq("s4 level_error", lerr_s[1], 1'b1);

        // Mid-stream reset, then the increment pattern again.
        do_reset();
        for (int k = 1; k <= 3; k++) step(b2g(4'(k)), 4'd0, 1'b0);
        repeat (6) step(b2g(4'd3), 4'd0, 1'b0);
        step(b2g(4'd4), 4'd0, 1'b0);
        do_reset();

        // Random traffic: mostly legal increments, occasional corruption, clears and resets.
        wb = '0;
        for (int c = 0; c < 1500; c++) begin
            roll = int'($urandom_range(0, 99));
            if (roll < 2) begin
                do_reset();
                wb = '0;
                step(4'd0, 4'd0, 1'b0);
            end else if (roll < 6) begin
                step(4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0);
            end else begin
                if ($urandom_range(0, 2) != 0) wb = wb + 4'd1;
                step(b2g(wb), wb - 4'($urandom_range(0, 8)), $urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
